// File: rtl/gruel_pkg.sv
// Shared types and coin values for the gruel vending controller.
package gruel_pkg;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      SHILLING = 2'd1,
      FLORIN   = 2'd2,
      CROWN    = 2'd3
   } coin_t;

   localparam logic [2:0] VAL_SHILLING = 3'd1;
   localparam logic [2:0] VAL_FLORIN   = 3'd2;
   localparam logic [2:0] VAL_CROWN    = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } vend_state_t;

endpackage

// File: rtl/gruel_vend_ctrl_coin_value.sv
// Combinational map from coin code to its value in shillings.
module coin_value
   import gruel_pkg::*;
(
   input  coin_t      coin,
   output logic [2:0] value
);

   always_comb begin
      value = 3'd0;
      case (coin)
         SHILLING: value = VAL_SHILLING;
         FLORIN:   value = VAL_FLORIN;
         CROWN:    value = VAL_CROWN;
         default:  value = 3'd0;
      endcase
   end

endmodule

// File: rtl/gruel_vend_ctrl.sv
// Coin-operated gruel vending FSM: collects credit, requests a vend, pays change
// in florins/shillings. All outputs come straight from flops.
module gruel_vend_ctrl
   import gruel_pkg::*;
#(
   parameter int PRICE      = 3,
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 2**CREDIT_W - 1
) (
   input  logic                clk50,
   input  logic                reset,
   input  logic                coin_strobe,
   input  logic [1:0]          coin_type,
   input  logic                cancel,
   input  logic                gruel_ack,
   input  logic                change_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic                gruel,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   output logic                coin_reject,
   output logic [1:0]          state_dbg
);

   // Extra headroom so credit + crown never wraps before the limit check.
   localparam int SUM_W = CREDIT_W + 3;

   vend_state_t         state, state_n;
   logic [CREDIT_W-1:0] credit_n;
   logic                reject_n;
   logic [1:0]          change_coin_n;
   coin_t               coin_in;
   logic [2:0]          coin_val;
   logic                coin_valid;
   logic [SUM_W-1:0]    sum;
   logic [CREDIT_W-1:0] change_val;

   assign coin_in    = coin_t'(coin_type);
   assign coin_valid = coin_strobe && (coin_in != NONE);
   assign sum        = SUM_W'(credit) + SUM_W'(coin_val);
   assign change_val = (credit > CREDIT_W'(1)) ? CREDIT_W'(2) : CREDIT_W'(1);

   coin_value u_coin_value (
      .coin  (coin_in),
      .value (coin_val)
   );

   always_comb begin
      state_n  = state;
      credit_n = credit;
      reject_n = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            // A simultaneous cancel beats the coin, which goes back to the user.
            if (state == COLLECT && cancel) begin
               state_n  = CHANGE;
               reject_n = coin_valid;
            end else if (coin_valid) begin
               if (sum <= SUM_W'(MAX_CREDIT)) begin
                  credit_n = CREDIT_W'(sum);
                  state_n  = (sum >= SUM_W'(PRICE)) ? VEND : COLLECT;
               end else begin
                  reject_n = 1'b1;
               end
            end
         end
         VEND: begin
            reject_n = coin_valid;
            if (gruel_ack) begin
               credit_n = credit - CREDIT_W'(PRICE);
               state_n  = (credit == CREDIT_W'(PRICE)) ? IDLE : CHANGE;
            end
         end
         CHANGE: begin
            reject_n = coin_valid;
            if (change_ack) begin
               credit_n = credit - change_val;
               state_n  = (credit == change_val) ? IDLE : CHANGE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Coin offer follows the post-edge credit, so it holds steady until acked.
   always_comb begin
      change_coin_n = 2'd0;
      if (state_n == CHANGE)
         change_coin_n = (credit_n > CREDIT_W'(1)) ? 2'd2 : 2'd1;
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         credit       <= '0;
         gruel        <= 1'b0;
         change_valid <= 1'b0;
         change_coin  <= 2'd0;
         coin_reject  <= 1'b0;
         state_dbg    <= 2'd0;
      end else begin
         state        <= state_n;
         credit       <= credit_n;
         gruel        <= (state_n == VEND);
         change_valid <= (state_n == CHANGE);
         change_coin  <= change_coin_n;
         coin_reject  <= reject_n;
         state_dbg    <= 2'(state_n);
      end
   end

endmodule

// File: tb/tb_gruel_vend_ctrl.sv
// Bench for gruel_vend_ctrl: default instance (PRICE=3, CREDIT_W=4) and a small
// instance (PRICE=6, CREDIT_W=3) for credit-limit cases, sharing one stimulus.
module tb_gruel_vend_ctrl;

   logic       clk50 = 1'b0;
   logic       reset = 1'b0;
   logic       coin_strobe = 1'b0;
   logic [1:0] coin_type = 2'd0;
   logic       cancel = 1'b0;
   logic       gruel_ack = 1'b0;
   logic       change_ack = 1'b0;

   logic [3:0] a_credit;
   logic       a_gruel, a_cv, a_rej;
   logic [1:0] a_cc, a_st;
   logic [2:0] b_credit;
   logic       b_gruel, b_cv, b_rej;
   logic [1:0] b_cc, b_st;

   always #5 clk50 = ~clk50;

   gruel_vend_ctrl dut_a (
      .clk50(clk50), .reset(reset), .coin_strobe(coin_strobe), .coin_type(coin_type),
      .cancel(cancel), .gruel_ack(gruel_ack), .change_ack(change_ack),
      .credit(a_credit), .gruel(a_gruel), .change_valid(a_cv), .change_coin(a_cc),
      .coin_reject(a_rej), .state_dbg(a_st)
   );

   gruel_vend_ctrl #(.PRICE(6), .CREDIT_W(3)) dut_b (
      .clk50(clk50), .reset(reset), .coin_strobe(coin_strobe), .coin_type(coin_type),
      .cancel(cancel), .gruel_ack(gruel_ack), .change_ack(change_ack),
      .credit(b_credit), .gruel(b_gruel), .change_valid(b_cv), .change_coin(b_cc),
      .coin_reject(b_rej), .state_dbg(b_st)
   );

   typedef struct {
      bit   rst;
      bit   sel;
      logic stb;
      logic [1:0] ct;
      logic can, ga, ca;
      int   cr, g, cv, cc, rej, st;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   step_no = 0;

   function automatic vec_t mk(bit rst, bit sel, logic stb, logic [1:0] ct, logic can,
                               logic ga, logic ca, int cr, int g, int cv, int cc,
                               int rej, int st);
      vec_t v;
      v.rst = rst; v.sel = sel; v.stb = stb; v.ct = ct; v.can = can; v.ga = ga; v.ca = ca;
      v.cr = cr; v.g = g; v.cv = cv; v.cc = cc; v.rej = rej; v.st = st;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (step %0d): got %0d expected %0d", nm, step_no, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " a_credit"}, int'(a_credit), 0);
      chk({tag, " a_outs"}, int'({a_gruel, a_cv, a_cc, a_rej, a_st}), 0);
      chk({tag, " b_credit"}, int'(b_credit), 0);
      chk({tag, " b_outs"}, int'({b_gruel, b_cv, b_cc, b_rej, b_st}), 0);
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      if (v.rst) begin
         reset = 1'b0;
         #2;
         @(posedge clk50);
         #1;
         reset = 1'b1;
      end
      coin_strobe = v.stb; coin_type = v.ct; cancel = v.can;
      gruel_ack = v.ga; change_ack = v.ca;
      sb.push_back(v);
      @(posedge clk50);
      #1;
      e = sb.pop_front();
      step_no++;
      if (!e.sel) begin
         chk("a_credit", int'(a_credit), e.cr);
         chk("a_gruel", int'(a_gruel), e.g);
         chk("a_change_valid", int'(a_cv), e.cv);
         chk("a_change_coin", int'(a_cc), e.cc);
         chk("a_coin_reject", int'(a_rej), e.rej);
         chk("a_state_dbg", int'(a_st), e.st);
         chk("a_exclusive", int'(a_gruel & a_cv), 0);
      end else begin
         chk("b_credit", int'(b_credit), e.cr);
         chk("b_gruel", int'(b_gruel), e.g);
         chk("b_change_valid", int'(b_cv), e.cv);
         chk("b_change_coin", int'(b_cc), e.cc);
         chk("b_coin_reject", int'(b_rej), e.rej);
         chk("b_state_dbg", int'(b_st), e.st);
         chk("b_exclusive", int'(b_gruel & b_cv), 0);
      end
   endtask

   initial begin
      // rst sel stb ct can ga ca | credit gruel cv cc rej state
      // none-coin strobe, cancel and stray acks in IDLE are all ignored
      tbl.push_back(mk(1,0, 1,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(0,0, 0,0,1,1,1, 0,0,0,0,0,0));
      // exact payment: florin + shilling
      tbl.push_back(mk(0,0, 1,2,0,0,0, 2,0,0,0,0,1));
      tbl.push_back(mk(0,0, 1,1,0,0,0, 3,1,0,0,0,2));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 3,1,0,0,0,2));
      tbl.push_back(mk(0,0, 0,0,0,1,0, 0,0,0,0,0,0));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0,0,0));
      // overpay with crown, busy rejects, held change_ack
      tbl.push_back(mk(1,0, 1,3,0,0,0, 5,1,0,0,0,2));
      tbl.push_back(mk(0,0, 1,2,1,0,1, 5,1,0,0,1,2));
      tbl.push_back(mk(0,0, 0,0,0,1,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 0,0,1,1,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 1,1,0,0,0, 2,0,1,2,1,3));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 0,0,0,0,1, 0,0,0,0,0,0));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0,0,0));
      // cancel wins over a simultaneous florin
      tbl.push_back(mk(1,0, 1,1,0,0,0, 1,0,0,0,0,1));
      tbl.push_back(mk(0,0, 1,1,0,0,0, 2,0,0,0,0,1));
      tbl.push_back(mk(0,0, 1,2,1,0,0, 2,0,1,2,1,3));
      tbl.push_back(mk(0,0, 0,0,0,0,0, 2,0,1,2,0,3));
      tbl.push_back(mk(0,0, 0,0,0,0,1, 0,0,0,0,0,0));
      // credit limit on the small instance (PRICE=6, max 7)
      tbl.push_back(mk(1,1, 1,3,0,0,0, 5,0,0,0,0,1));
      tbl.push_back(mk(0,1, 1,3,0,0,0, 5,0,0,0,1,1));
      tbl.push_back(mk(0,1, 0,0,0,0,0, 5,0,0,0,0,1));
      tbl.push_back(mk(0,1, 1,2,0,0,0, 7,1,0,0,0,2));
      tbl.push_back(mk(0,1, 0,0,0,1,0, 1,0,1,1,0,3));
      tbl.push_back(mk(0,1, 0,0,0,0,0, 1,0,1,1,0,3));
      tbl.push_back(mk(0,1, 0,0,0,0,1, 0,0,0,0,0,0));
      // drive the default instance into CHANGE before the async reset check
      tbl.push_back(mk(1,0, 1,3,0,0,0, 5,1,0,0,0,2));
      tbl.push_back(mk(0,0, 0,0,0,1,0, 2,0,1,2,0,3));

      reset = 1'b0;
      #12;
      chk_zero("reset_hold");

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i]);

      // asynchronous reset mid-cycle during CHANGE
      coin_strobe = 1'b0; gruel_ack = 1'b0; change_ack = 1'b0; cancel = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk_zero("async_reset");
      @(posedge clk50);
      #1;
      chk_zero("reset_edge");
      reset = 1'b1;
      // first edge after release accepts a coin
      step(mk(0,0, 1,2,0,0,0, 2,0,0,0,0,1));
      step(mk(0,0, 0,0,0,0,0, 2,0,0,0,0,1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gruel_vend_ctrl.md
GRUEL_VEND_CTRL -- requirements
Module: gruel_vend_ctrl

Interface
REQ-001 Parameter: PRICE, default 3, gruel price in shillings; legal range 1..MAX_CREDIT.
REQ-002 Parameter: CREDIT_W, default 4, width of the credit register.
REQ-003 Parameter: MAX_CREDIT, default 2**CREDIT_W-1, highest credit accepted.
REQ-004 clk50  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 coin_strobe  in  1  one-cycle pulse: a coin is presented.
REQ-007 coin_type  in  2  0 none, 1 shilling (1), 2 florin (2), 3 crown (5).
REQ-008 cancel  in  1  refund request, level-sampled each cycle.
REQ-009 gruel_ack  in  1  dispenser has taken the gruel.
REQ-010 change_ack  in  1  coin hopper has taken the offered change coin.
REQ-011 credit  out  CREDIT_W  current credit in shillings.
REQ-012 gruel  out  1  vend request; held until gruel_ack.
REQ-013 change_valid  out  1  change coin offered.
REQ-014 change_coin  out  2  coin offered, encoded as coin_type; only 1 or 2 are legal.
REQ-015 coin_reject  out  1  one-cycle pulse: the coin was returned, not credited.
REQ-016 state_dbg  out  2  encoded FSM state, for the seven-segment and LED debug.

Function
REQ-017 The FSM SHALL have four states: IDLE (credit 0), COLLECT, VEND and CHANGE.
REQ-018 A coin_strobe with coin_type 0 SHALL be ignored: no credit change and no reject.
REQ-019 In IDLE or COLLECT, a valid coin whose value keeps credit+value <= MAX_CREDIT SHALL be added to credit at the next edge.
REQ-020 A valid coin that would exceed MAX_CREDIT SHALL leave credit unchanged and pulse coin_reject for one cycle.
REQ-021 A valid coin arriving in VEND or CHANGE SHALL pulse coin_reject and not be credited.
REQ-022 When the credit after an accepted coin is >= PRICE, the FSM SHALL enter VEND at that same edge, so gruel rises one cycle after the strobe; otherwise it SHALL enter or stay in COLLECT.
REQ-023 In VEND, gruel SHALL stay 1 until gruel_ack.
REQ-024 On gruel_ack in VEND, credit SHALL become credit-PRICE, and the FSM SHALL go to IDLE if the result is 0, else to CHANGE.
REQ-025 cancel in COLLECT SHALL move the FSM to CHANGE with credit intact.
REQ-026 cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-027 If cancel and a valid coin_strobe occur in the same COLLECT cycle, cancel SHALL win and the coin SHALL be rejected.
REQ-028 In CHANGE, change_valid SHALL be 1.
REQ-029 In CHANGE, change_coin SHALL be florin if credit >= 2, else shilling; crowns are never paid out.
REQ-030 change_coin SHALL stay stable while change_valid=1 and change_ack=0.
REQ-031 On change_ack, credit SHALL drop by the offered coin's value; when it reaches 0 the FSM SHALL go to IDLE and change_valid SHALL fall the next cycle.
REQ-032 gruel and change_valid SHALL never both be 1.
REQ-033 All outputs SHALL be registered.
REQ-034 gruel_ack outside VEND and change_ack outside CHANGE SHALL be ignored.

Reset
REQ-035 While reset=0, the FSM SHALL be in IDLE, credit=0, and gruel, change_valid, change_coin, coin_reject and state_dbg SHALL be 0, taking effect immediately without a clock edge.
REQ-036 Reset during VEND or CHANGE SHALL abandon the transaction with no further outputs.
REQ-037 The first edge after reset release SHALL accept coins normally.

Structure
REQ-038 Shared package gruel_pkg SHALL hold the coin_t enum (NONE, SHILLING, FLORIN, CROWN), the coin-value constants 1/2/5, and the vend_state_t enum.
REQ-039 A single combinational sub-module, coin_value, SHALL map coin_t to its shilling value; all other logic SHALL stay in gruel_vend_ctrl.

Verification
REQ-040 Reset test: reset low mid-operation -> credit=0, all outputs 0 immediately, state_dbg=IDLE.
REQ-041 Exact payment (PRICE=3): florin then shilling -> credit 2, then 3; gruel=1 the cycle after the second strobe; gruel_ack -> IDLE, credit 0, no change offered.
REQ-042 Overpay with held ack: crown -> gruel; gruel_ack -> credit 2, change_valid=1, change_coin=2; hold change_ack low 5 cycles -> change_coin stable; change_ack -> IDLE.
REQ-043 Cancel: shilling, shilling, then cancel together with a florin strobe -> coin_reject pulses; refund = one florin, credit returns to 0.
REQ-044 Overflow (CREDIT_W=3, PRICE=6): crown -> credit 5; crown -> coin_reject, credit stays 5; florin -> credit 7, VEND; gruel_ack -> change shilling.
REQ-045 Busy reject: a coin strobed during VEND and during CHANGE -> coin_reject pulses, credit unaffected.
